cla_sub_serial: RTL and testbench

- Multi-cycle unsigned subtractor computing D = A - B - BIN over a WIDTH-bit word.
- Processes one 4-bit slice per clock through a borrow-lookahead nibble stage; borrow ripples between slices via a register.
- Sits beside the 4-bit carry-lookahead adder slices in the arithmetic datapath.
- Uses valid/ready handshakes on both input and result sides.

---
 rtl/cla_sub_serial.sv | 116 +++++++++++
 tb/tb_cla_sub_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_serial.sv
// Nibble-serial unsigned subtractor: D = A - B - b_1, one borrow-lookahead slice per clock.
// Optional CLA_SUB_SERIAL_OVF_EN adds a signed-overflow output.
module cla_sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             zero
`ifdef CLA_SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [3:0]       sa, sb, g, p, c, s;
    logic             cin, cout;
    logic [WIDTH-1:0] diff_nx;

    // Subtraction as a + ~b + ~borrow through a 4-bit carry-lookahead slice
    always_comb begin
        sa      = a_q[4*cnt +: 4];
        sb      = ~b_q[4*cnt +: 4];
        cin     = ~borrow;
        g       = sa & sb;
        p       = sa ^ sb;
        c[0]    = cin;
        c[1]    = g[0] | (p[0] & cin);
        c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
        cout    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
        s       = p ^ c;
        diff_nx = diff;
        diff_nx[4*cnt +: 4] = s;
    end

    assign bo = borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            borrow    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            diff      <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
`ifdef CLA_SUB_SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        borrow   <= b_1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    diff   <= diff_nx;
                    borrow <= ~cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        zero      <= (diff_nx == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef CLA_SUB_SERIAL_OVF_EN
                        ovf <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                             & (a_q[WIDTH-1] ^ diff_nx[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_serial.sv
// Directed bench for cla_sub_serial (WIDTH=16): vector table plus
// backpressure and mid-run reset sequences.
module tb_cla_sub_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        b_1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bo;
    logic        zero;
`ifdef CLA_SUB_SERIAL_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    cla_sub_serial #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .b_1       (b_1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bo        (bo),
        .zero      (zero)
`ifdef CLA_SUB_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        ov;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic bin);
        int w;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        b_1      = bin;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic take_result;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string name, input vec_t v);
        int n;
        start_op(v.a, v.b, v.bin);
        wait_done(n);
        chk({name, "_latency"}, 32'(n), 32'd4);
        chk({name, "_diff"}, 32'(diff), 32'(v.d));
        chk({name, "_bo"}, 32'(bo), 32'(v.bo));
        chk({name, "_zero"}, 32'(zero), 32'(v.z));
`ifdef CLA_SUB_SERIAL_OVF_EN
        chk({name, "_ovf"}, 32'(ovf), 32'(v.ov));
`endif
        chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
        take_result();
    endtask

    initial begin
        int n;
        vec_t v;
        vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h0100, 16'h00FF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        b_1       = 1'b0;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bo", 32'(bo), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result held while out_ready low, new op waits
        start_op(16'h00F0, 16'h000F, 1'b0);
        wait_done(n);
        chk("bp_latency", 32'(n), 32'd4);
        a_in     = 16'h0005;
        b_in     = 16'h0003;
        b_1      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'h00E1);
            chk("bp_bo", 32'(bo), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_in_ready", 32'(in_ready), 32'd0);
        wait_done(n);
        chk("bp2_latency", 32'(n), 32'd4);
        chk("bp2_diff", 32'(diff), 32'h0002);
        chk("bp2_bo", 32'(bo), 32'd0);
        take_result();

        // Reset asserted during the second RUN cycle
        start_op(16'h1234, 16'h0001, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bo", 32'(bo), 32'd0);
        chk("mid_rst_zero", 32'(zero), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_idle_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_no_pulse", 32'(out_valid), 32'd0);
        v = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0};
        run_op("after_rst", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
